// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped, read-only instruction cache.
// Hits return in one cycle; misses refill a whole line word-by-word, then respond.
module icache_fetch #(
  parameter int unsigned ADDR_SIZE       = 32,
  parameter int unsigned WD_SIZE         = 32,
  parameter int unsigned CACHE_LINE_SIZE = 64,
  parameter int unsigned CACHE_NUM_LINES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic [ADDR_SIZE-1:0] req_addr,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [WD_SIZE-1:0]   resp_instr,
  input  logic                 flush,
  output logic                 mem_req_valid,
  output logic [ADDR_SIZE-1:0] mem_req_addr,
  input  logic                 mem_req_ready,
  input  logic                 mem_rvalid,
  input  logic [WD_SIZE-1:0]   mem_rdata
);

  localparam int unsigned BYTE_W = $clog2(WD_SIZE / 8);
  localparam int unsigned WORDS  = CACHE_LINE_SIZE / (WD_SIZE / 8);
  localparam int unsigned OFF_W  = $clog2(CACHE_LINE_SIZE);
  localparam int unsigned WSEL_W = $clog2(WORDS);
  localparam int unsigned IDX_W  = $clog2(CACHE_NUM_LINES);
  localparam int unsigned TAG_W  = ADDR_SIZE - OFF_W - IDX_W;
  localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(WORDS - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MREQ   = 2'd1;
  localparam logic [1:0] REFILL = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [CACHE_NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]           tag_q  [CACHE_NUM_LINES];
  logic [WD_SIZE-1:0]         data_q [CACHE_NUM_LINES][WORDS];
  logic                       pend_flush_q;
  logic [WSEL_W-1:0]          cnt_q;
  logic [IDX_W-1:0]           cap_idx_q;
  logic [TAG_W-1:0]           cap_tag_q;
  logic [WSEL_W-1:0]          cap_wsel_q;

  logic [WSEL_W-1:0] req_wsel;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic              accept;
  logic              beat;
  logic              last_beat;
  logic              unused_addr_bits;

  // Address split and combinational tag lookup
  assign req_wsel         = req_addr[OFF_W-1:BYTE_W];
  assign req_idx          = req_addr[OFF_W+IDX_W-1:OFF_W];
  assign req_tag          = req_addr[ADDR_SIZE-1:OFF_W+IDX_W];
  assign hit              = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign accept           = req_valid && req_ready;
  assign beat             = (state_q == REFILL) && mem_rvalid;
  assign last_beat        = beat && (cnt_q == LAST_BEAT);
  assign unused_addr_bits = ^req_addr[BYTE_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and the combinational request-ready
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !rst && !flush && !pend_flush_q;
        if (req_valid && req_ready && !hit) state_d = MREQ;
      end
      MREQ:    if (mem_req_ready) state_d = REFILL;
      REFILL:  if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control, response and refill-request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      pend_flush_q  <= 1'b0;
      resp_valid    <= 1'b0;
      resp_instr    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      cnt_q         <= '0;
      cap_idx_q     <= '0;
      cap_tag_q     <= '0;
      cap_wsel_q    <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush || pend_flush_q) begin
            valid_q      <= '0;
            pend_flush_q <= 1'b0;
          end
          if (accept && hit) begin
            resp_valid <= 1'b1;
            resp_instr <= data_q[req_idx][req_wsel];
          end else if (accept) begin
            cap_idx_q     <= req_idx;
            cap_tag_q     <= req_tag;
            cap_wsel_q    <= req_wsel;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {req_addr[ADDR_SIZE-1:OFF_W], OFF_W'(0)};
          end
        end
        MREQ: begin
          if (flush) pend_flush_q <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt_q         <= '0;
          end
        end
        REFILL: begin
          if (flush) pend_flush_q <= 1'b1;
          if (beat) begin
            cnt_q <= cnt_q + WSEL_W'(1);
            if (cnt_q == cap_wsel_q) resp_instr <= mem_rdata;
            if (last_beat) begin
              valid_q[cap_idx_q] <= 1'b1;
              resp_valid         <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line data and tag storage, written only by refill beats
  always_ff @(posedge clk) begin
    if (!rst && beat) begin
      data_q[cap_idx_q][cnt_q] <= mem_rdata;
      if (last_beat) tag_q[cap_idx_q] <= cap_tag_q;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch with a response scoreboard and a memory model
// that returns each word's own address as its data.
module tb_icache_fetch;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_instr;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int vectors;
  int miscompares;
  logic [31:0] exp_q[$];

  icache_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_instr    (resp_instr),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard head and compare it with the current response word
  task automatic check_resp(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, resp_instr, e);
    end
  endtask

  // Present a request until accepted (bounded); returns after the accepting edge
  task automatic issue(input logic [31:0] addr);
    int n;
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // One fetch: hit, or miss with optional backpressure, flush or reset mid-refill
  task automatic fetch(input logic [31:0] addr, input bit exp_hit, input int stall,
                       input int flush_beat, input int rst_beat);
    logic [31:0] line;
    logic [31:0] e;
    bit          aborted;
    line = {addr[31:6], 6'b0};
    exp_q.push_back({addr[31:2], 2'b00});
    issue(addr);
    if (exp_hit) begin
      check("hit_no_mreq", {31'd0, mem_req_valid}, 32'd0);
    end else begin
      check("miss_mreq_valid", {31'd0, mem_req_valid}, 32'd1);
      check("miss_mreq_addr", mem_req_addr, line);
      check("miss_no_resp", {31'd0, resp_valid}, 32'd0);
      for (int i = 0; i < stall; i++) begin
        tick();
        check("stall_mreq_valid", {31'd0, mem_req_valid}, 32'd1);
        check("stall_mreq_addr", mem_req_addr, line);
        check("stall_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      check("mreq_drop", {31'd0, mem_req_valid}, 32'd0);
      aborted = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (k == 3) begin
          mem_rdata = 32'hDEADBEEF;
          tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = line + 32'(4 * k);
        flush      = (k == flush_beat);
        tick();
        mem_rvalid = 1'b0;
        flush      = 1'b0;
        if (k == rst_beat) begin
          aborted = 1'b1;
          break;
        end
        if (k < 15) check("beat_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      if (aborted) begin
        rst = 1'b1;
        tick();
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_instr", resp_instr, 32'd0);
        check("rst_mreq_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_mreq_addr", mem_req_addr, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", {31'd0, req_ready}, 32'd1);
        e = exp_q.pop_back();
        tick();
        check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
        return;
      end
      check("miss_ready_after", {31'd0, req_ready}, (flush_beat >= 0) ? 32'd0 : 32'd1);
    end
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    e = {addr[31:2], 2'b00};
    check_resp("resp_instr");
    tick();
    check("resp_pulse_once", {31'd0, resp_valid}, 32'd0);
    check("resp_hold", resp_instr, e);
    if (flush_beat >= 0) check("post_flush_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_addr      = 32'd0;
    flush         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = 32'd0;

    // Reset values
    tick();
    tick();
    check("reset_req_ready", {31'd0, req_ready}, 32'd0);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_resp_instr", resp_instr, 32'd0);
    check("reset_mreq_valid", {31'd0, mem_req_valid}, 32'd0);
    check("reset_mreq_addr", mem_req_addr, 32'd0);
    rst = 1'b0;
    #1;
    check("reset_release_ready", {31'd0, req_ready}, 32'd1);
    tick();

    // Cold miss, then hit
    fetch(32'h0000_1000, 1'b0, 0, -1, -1);
    fetch(32'h0000_103C, 1'b1, 0, -1, -1);

    // Back-to-back hits, one per cycle
    req_valid = 1'b1;
    req_addr  = 32'h0000_1010;
    exp_q.push_back(32'h0000_1010);
    #1;
    check("b2b_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_addr = 32'h0000_1017;
    exp_q.push_back(32'h0000_1014);
    check("b2b_resp0_valid", {31'd0, resp_valid}, 32'd1);
    check_resp("b2b_resp0");
    tick();
    req_valid = 1'b0;
    check("b2b_resp1_valid", {31'd0, resp_valid}, 32'd1);
    check_resp("b2b_resp1");
    check("b2b_no_mreq", {31'd0, mem_req_valid}, 32'd0);
    tick();
    check("b2b_end", {31'd0, resp_valid}, 32'd0);

    // Conflict on index 0 evicts 0x1000
    fetch(32'h0000_1104, 1'b0, 0, -1, -1);
    fetch(32'h0000_1000, 1'b0, 0, -1, -1);

    // Refill request backpressure
    fetch(32'h0000_2084, 1'b0, 5, -1, -1);
    fetch(32'h0000_20BC, 1'b1, 0, -1, -1);

    // Flush in IDLE
    flush = 1'b1;
    #1;
    check("idle_flush_ready", {31'd0, req_ready}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("idle_flush_ready_after", {31'd0, req_ready}, 32'd1);
    fetch(32'h0000_2088, 1'b0, 0, -1, -1);

    // Flush during refill beat 7: both new and previously resident lines miss
    fetch(32'h0000_30C0, 1'b0, 0, 7, -1);
    fetch(32'h0000_30C4, 1'b0, 0, -1, -1);
    fetch(32'h0000_2080, 1'b0, 0, -1, -1);

    // Reset after beat 9, then a full refill of the same line
    fetch(32'h0000_4040, 1'b0, 0, -1, 9);
    fetch(32'h0000_4048, 1'b0, 0, -1, -1);
    fetch(32'h0000_407C, 1'b1, 0, -1, -1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
# icache_fetch

Direct-mapped, read-only instruction cache between the fetch stage (upstream, issues PCs) and the instruction memory/bus (downstream, returns words). It serves hits in one cycle. On a miss it refills a whole line word-by-word from memory and then returns the requested instruction. The geometry is the core cache configuration: 64-byte lines and 4 lines.

## Interface
Parameters:
- `ADDR_SIZE`, default 32: address width.
- `WD_SIZE`, default 32: instruction/data word width.
- `CACHE_LINE_SIZE`, default 64: line size in bytes, 16 words.
- `CACHE_NUM_LINES`, default 4: number of lines. Must be a power of 2.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst`  in  1  reset. **Synchronous, active-high.**
- `req_valid`  in  1  fetch request.
- `req_addr`  in  32  fetch PC. Bits [1:0] are ignored.
- `req_ready`  out  1  the cache can accept a request this cycle.
- `resp_valid`  out  1  one-cycle pulse when `resp_instr` is valid.
- `resp_instr`  out  32  returned instruction.
- `flush`  in  1  invalidate all lines.
- `mem_req_valid`  out  1  line-refill request.
- `mem_req_addr`  out  32  line-aligned refill address, bits [5:0] = 0.
- `mem_req_ready`  in  1  memory accepts the refill request.
- `mem_rvalid`  in  1  one refill word is present.
- `mem_rdata`  in  32  refill word. Words arrive in ascending address order.

## Operation
- Address split for the defaults:
  - offset = [5:0], word select = [5:2];
  - index = [7:6];
  - tag = [31:8].
- Storage per line: a valid bit, a 24-bit tag and 16 × 32-bit data words.
- FSM states are IDLE, MREQ and REFILL. Reset enters IDLE.
- IDLE:
  - `req_ready` = 1 unless `flush` or a pending flush is being applied.
  - An accepted request (`req_valid & req_ready`) is looked up combinationally.
  - Hit: the word is registered to `resp_instr` and `resp_valid` = 1 next cycle. Stay in IDLE.
  - Miss: capture the index, tag and word select. `mem_req_addr` = {req_addr[31:6], 6'b0}. Go to MREQ.
- MREQ:
  - `mem_req_valid` = 1 and `mem_req_addr` is held stable until `mem_req_ready`.
  - On handshake, clear the 4-bit beat counter and go to REFILL.
- REFILL:
  - Each `mem_rvalid` writes `mem_rdata` to data[index][counter] and increments the counter.
  - When counter == captured word select, the beat is also copied into the response register.
  - On beat 15, set valid[index] = 1 and tag[index] = captured tag. `resp_valid` = 1 next cycle. Return to IDLE.
  - The counter wraps 15 -> 0. It is only meaningful inside REFILL.
- `mem_rvalid` is ignored outside REFILL.
- `req_valid` is ignored while `req_ready` = 0. The requester must hold the request.
- Flush:
  - In IDLE: clears all valid bits that cycle and forces `req_ready` = 0, so no lookup happens in the same cycle.
  - In MREQ/REFILL: a pending-flush flag is set. The refill completes normally, then the flush is applied in the first IDLE cycle with `req_ready` = 0.
- The line written by a refill that precedes a pending flush ends up invalid.
- Reset mid-refill: the FSM returns to IDLE and all valid bits clear. The partial line is never marked valid and no response is produced. The data/tag arrays need no reset.

## Timing
Reset values:
- `req_ready` = 0 during reset and 1 the first cycle after.
- `resp_valid` = 0.
- `resp_instr` = 32'h00000000 (NOP).
- `mem_req_valid` = 0 and `mem_req_addr` = 0.
- All valid bits = 0 and the pending-flush flag = 0.

Latency and throughput:
- Hit: request accepted at cycle N gives `resp_valid` at N+1. Back-to-back hits sustain 1 per cycle.
- Miss: accepted at N, `mem_req_valid` from N+1, handshake at H, beats at cycles > H, last beat at L. `resp_valid` is at L+1, with `req_ready` = 1 at L+1.

Output rules:
- `resp_instr` holds its last value between pulses.
- `mem_req_valid` drops the cycle after the handshake.
- `resp_valid` never rises without a preceding accepted request.

## Test plan
- Cold miss: reset, then request 0x00001000. Expect `mem_req_addr` = 0x00001000. Memory returns words 0x1000+4k for k=0..15, then `resp_instr` = 0x00001000 and `resp_valid` pulses once.
- Hit: after line 0x1000 is resident, request 0x0000103C. Expect `resp_valid` in the next cycle, `resp_instr` = 0x0000103C, and `mem_req_valid` stays 0.
- Conflict: with 0x1000 resident, request 0x00001104. Expect a refill of 0x00001100. A later request to 0x1000 misses again.
- Backpressure: hold `mem_req_ready` = 0 for 5 cycles. Expect `mem_req_valid` and `mem_req_addr` stable throughout, and no `resp_valid`.
- Flush: pulse `flush` in IDLE, and separately during REFILL beat 7. In both cases the next request to the same line misses. `req_ready` is 0 in the cycle the flush is applied.
- Reset mid-refill: assert `rst` after beat 9. Expect all outputs at reset values. The next request to that line misses and refills all 16 beats.
